// File: rtl/alu_pipe_if.sv
// Issue/result bus for alu_pipe: issue handshake, operands, and registered result/flags.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int IMMW  = 5,
    parameter int TAGW  = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [11:0]            alusignals;
    logic [WIDTH-1:0]       op1;
    logic [WIDTH-1:0]       op2;
    logic [IMMW-1:0]        immx;
    logic                   isimmediate;
    logic [TAGW-1:0]        rd;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       aluresult;
    logic [TAGW+WIDTH-1:0]  rdval;
    logic                   flag_eq;
    logic                   flag_gt;
    logic                   busy;

    modport master (
        output in_valid, alusignals, op1, op2, immx, isimmediate, rd, out_ready,
        input  in_ready, out_valid, aluresult, rdval, flag_eq, flag_gt, busy
    );

    modport slave (
        input  in_valid, alusignals, op1, op2, immx, isimmediate, rd, out_ready,
        output in_ready, out_valid, aluresult, rdval, flag_eq, flag_gt, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with one-entry output register, compare flags and a multi-cycle multiplier.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int IMMW    = 5,
    parameter int TAGW    = 3,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_MUL = 4'd3,
        OP_OR  = 4'd4, OP_AND = 4'd5, OP_NOT = 4'd6, OP_MOV = 4'd7,
        OP_LSL = 4'd8, OP_LSR = 4'd9, OP_ASR = 4'd10, OP_NOP = 4'd11
    } op_t;

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]  mul_a_r, mul_b_r;
    logic [TAGW-1:0]   mul_tag_r;
    logic [WIDTH-1:0]  res_r;
    logic [TAGW-1:0]   tag_r;
    logic              out_valid_r, flag_eq_r, flag_gt_r;

    logic [WIDTH-1:0]  b_s, alu_s, wr_data_s;
    logic [TAGW-1:0]   wr_tag_s;
    op_t               op_s;
    logic              in_ready_s, fire_s, single_s, shamt_big_s, mul_done_s, wr_s;

    assign b_s        = bus.isimmediate ? {{(WIDTH-IMMW){bus.immx[IMMW-1]}}, bus.immx} : bus.op2;
    assign in_ready_s = !rst && (state_r == S_IDLE) && (!out_valid_r || bus.out_ready);
    assign fire_s     = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = (state_r == S_MUL);
    assign bus.out_valid = out_valid_r;
    assign bus.aluresult = res_r;
    assign bus.rdval     = {tag_r, res_r};
    assign bus.flag_eq   = flag_eq_r;
    assign bus.flag_gt   = flag_gt_r;

    // Priority decode: the lowest set select bit wins; bit 11 or no bits is a nop.
    always_comb begin
        op_s = OP_NOP;
        casez (bus.alusignals)
            12'b????_????_???1: op_s = OP_ADD;
            12'b????_????_??10: op_s = OP_SUB;
            12'b????_????_?100: op_s = OP_CMP;
            12'b????_????_1000: op_s = OP_MUL;
            12'b????_???1_0000: op_s = OP_OR;
            12'b????_??10_0000: op_s = OP_AND;
            12'b????_?100_0000: op_s = OP_NOT;
            12'b????_1000_0000: op_s = OP_MOV;
            12'b???1_0000_0000: op_s = OP_LSL;
            12'b??10_0000_0000: op_s = OP_LSR;
            12'b?100_0000_0000: op_s = OP_ASR;
            default:            op_s = OP_NOP;
        endcase
    end

    // Single-cycle datapath; single_s marks ops that write the output register.
    always_comb begin
        alu_s       = '0;
        single_s    = 1'b1;
        shamt_big_s = (b_s >= SH_LIM);
        case (op_s)
            OP_ADD:  alu_s = bus.op1 + b_s;
            OP_SUB:  alu_s = bus.op1 - b_s;
            OP_OR:   alu_s = bus.op1 | b_s;
            OP_AND:  alu_s = bus.op1 & b_s;
            OP_NOT:  alu_s = ~bus.op1;
            OP_MOV:  alu_s = b_s;
            OP_LSL:  alu_s = shamt_big_s ? '0 : (bus.op1 << b_s);
            OP_LSR:  alu_s = shamt_big_s ? '0 : (bus.op1 >> b_s);
            OP_ASR:  alu_s = shamt_big_s ? {WIDTH{bus.op1[WIDTH-1]}} : WIDTH'($signed(bus.op1) >>> b_s);
            default: begin
                alu_s    = '0;
                single_s = 1'b0;
            end
        endcase
    end

    // Multiply FSM next state: count down from MUL_LAT-1, finish when the counter reads zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mul_done_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fire_s && (op_s == OP_MUL)) begin
                    state_nxt_s = S_MUL;
                    cnt_nxt_s   = CW'(MUL_LAT - 1);
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_r == '0) begin
                    mul_done_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output register write select; a finishing multiply can never collide with an issue.
    always_comb begin
        wr_s      = 1'b0;
        wr_data_s = '0;
        wr_tag_s  = '0;
        if (mul_done_s) begin
            wr_s      = 1'b1;
            wr_data_s = mul_a_r * mul_b_r;
            wr_tag_s  = mul_tag_r;
        end else if (fire_s && single_s) begin
            wr_s      = 1'b1;
            wr_data_s = alu_s;
            wr_tag_s  = bus.rd;
        end else begin
            wr_s      = 1'b0;
        end
    end

    // FSM state and countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Operand latch, result register, valid tracking and compare flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            mul_tag_r   <= '0;
            res_r       <= '0;
            tag_r       <= '0;
            out_valid_r <= 1'b0;
            flag_eq_r   <= 1'b0;
            flag_gt_r   <= 1'b0;
        end else begin
            if (fire_s && (op_s == OP_MUL)) begin
                mul_a_r   <= bus.op1;
                mul_b_r   <= b_s;
                mul_tag_r <= bus.rd;
            end
            if (wr_s) begin
                res_r       <= wr_data_s;
                tag_r       <= wr_tag_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (fire_s && (op_s == OP_CMP)) begin
                flag_eq_r <= (bus.op1 == b_s);
                flag_gt_r <= ($signed(bus.op1) > $signed(b_s));
            end
        end
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (>=8).
REQ-002 Parameter IMMW, default 5, immediate field width in bits (<WIDTH).
REQ-003 Parameter TAGW, default 3, destination-register tag width.
REQ-004 Parameter MUL_LAT, default 2, multiply latency in cycles (>=2).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  issue request valid.
REQ-008 in_ready  output  1  block can accept an issue this cycle.
REQ-009 alusignals  input  12  one-hot op: bit0 add, 1 sub, 2 cmp, 3 mul, 4 or, 5 and, 6 not, 7 mov, 8 lsl, 9 lsr, 10 asr, 11 reserved.
REQ-010 op1, op2  input  WIDTH each  source operands.
REQ-011 immx  input  IMMW  immediate field.
REQ-012 isimmediate  input  1  use sign-extended immx in place of op2.
REQ-013 rd  input  TAGW  destination tag carried with the op.
REQ-014 out_valid  output  1  result register holds a valid result.
REQ-015 out_ready  input  1  consumer accepts result this cycle.
REQ-016 aluresult  output  WIDTH  registered result.
REQ-017 rdval  output  TAGW+WIDTH  {tag, aluresult}, tag in MSBs.
REQ-018 flag_eq, flag_gt  output  1 each  registered compare flags.
REQ-019 busy  output  1  multiply in progress.

Function
REQ-020 Issue fires when in_valid && in_ready; inputs are sampled only on a firing edge.
REQ-021 in_ready = !busy && (!out_valid || out_ready), combinational.
REQ-022 Effective op2 (B) = isimmediate ? sign-extend(immx) to WIDTH : op2.
REQ-023 Multi-hot alusignals: lowest set bit wins; zero-hot or bit11 = nop (accepted, no result, no flag change).
REQ-024 add/sub: op1+B / op1-B modulo 2^WIDTH, no carry output.
REQ-025 or/and: bitwise with B; not: ~op1; mov: B.
REQ-026 Shift amount = B as unsigned; lsl/lsr give 0 when amount >= WIDTH; asr gives WIDTH copies of op1 MSB when amount >= WIDTH.
REQ-027 Single-cycle ops: result and {rd,result} land in the output register on the firing edge; out_valid high next cycle (latency 1).
REQ-028 cmp: on the firing edge flag_eq <= (op1==B), flag_gt <= signed(op1) > signed(B); no result produced, output register untouched.
REQ-029 mul: FSM IDLE -> MUL on firing edge; counter loads MUL_LAT-1; busy high while in MUL.
REQ-030 In MUL the counter decrements each cycle; at 0 the low WIDTH bits of op1*B (latched operands) are written to the output register, out_valid set, FSM -> IDLE; out_valid first high MUL_LAT cycles after issue.
REQ-031 out_valid clears on an edge with out_ready high unless a new result is written the same edge (new result wins, out_valid stays high).
REQ-032 Output register, aluresult, rdval hold stable while out_valid && !out_ready.
REQ-033 Back-to-back single-cycle issue with out_ready held high sustains one result per cycle.
REQ-034 Flags unchanged by any op other than cmp.

Reset
REQ-035 On rst: FSM = IDLE, counter = 0, busy = 0, out_valid = 0, aluresult = 0, rdval = 0, flag_eq = 0, flag_gt = 0.
REQ-036 rst asserted mid-multiply abandons the operation; no result is ever produced for it.
REQ-037 rst takes priority over a simultaneous issue; that issue is dropped.
REQ-038 in_ready is 0 during the rst cycle and 1 the cycle after.

Verification (WIDTH=16, MUL_LAT=2)
REQ-039 add op1=0x0010, op2=0x0005, rd=3, out_ready=1 -> next cycle aluresult=0x0015, rdval=0x30015, out_valid=1.
REQ-040 sub op1=0x0000, op2=0x0001 -> aluresult=0xFFFF; asr op1=0x8000, op2=20 -> 0xFFFF; lsl op1=0x0001, op2=16 -> 0x0000.
REQ-041 mov isimmediate=1, immx=5'b10101 -> aluresult=0xFFF5.
REQ-042 mul 0x0100*0x0100 -> busy=1, in_ready=0 for 2 cycles, then aluresult=0x0000; mul 0x0007*0x0003 -> 0x0015.
REQ-043 cmp op1=0xFFFF, op2=0x0001 -> flag_eq=0, flag_gt=0, out_valid unchanged; cmp 0x000A vs 0x000A -> flag_eq=1.
REQ-044 out_ready=0 with valid result -> in_ready=0, result held; rst during mul -> out_valid stays 0.
